// File: rtl/othello_pkg.sv
// Shared definitions for the Othello turn controller and its neighbours.
// Colour encoding: 1 = black, 0 = white.
package othello_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PROBE    = 3'd1,
    S_WAIT_HUM = 3'd2,
    S_AI_RUN   = 3'd3,
    S_UPD_RUN  = 3'd4,
    S_NEXT     = 3'd5,
    S_OVER     = 3'd6
  } state_t;

  localparam logic       BLACK     = 1'b1;
  localparam logic       WHITE     = 1'b0;
  localparam logic [1:0] EMPTY     = 2'b00;
  localparam logic [5:0] MAX_MOVES = 6'd60;

endpackage

// File: rtl/turn_ctrl.sv
// Turn sequencer for an Othello game: probes the AI engine for move availability,
// collects human or AI moves, dispatches them to the board updater and detects game end.
//
// state    | meaning
// IDLE     | no game running since reset
// PROBE    | AI engine searching for a legal move for o_turn
// WAIT_HUM | waiting for the human player's move
// AI_RUN   | reserved; the PROBE result already is the AI move
// UPD_RUN  | board updater applying the latched move
// NEXT     | end-of-game check between turns
// OVER     | game finished (or AI produced an illegal move)
module turn_ctrl
  import othello_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_new_game,
  input  logic       i_ai_color,
  input  logic       i_hum_valid,
  output logic       o_hum_ready,
  input  logic [2:0] i_hum_row,
  input  logic [2:0] i_hum_col,
  output logic       o_ai_start,
  output logic       o_ai_color,
  input  logic       i_ai_done,
  input  logic       i_ai_end,
  input  logic [2:0] i_ai_row,
  input  logic [2:0] i_ai_col,
  output logic       o_upd_start,
  output logic       o_upd_color,
  output logic [2:0] o_upd_row,
  output logic [2:0] o_upd_col,
  input  logic       i_upd_done,
  input  logic [4:0] i_upd_flip,
  output logic       o_turn,
  output logic [5:0] o_move_cnt,
  output logic       o_illegal,
  output logic       o_pass,
  output logic       o_game_over
);

  state_t     state, state_nxt;
  logic       entry;
  logic       turn;
  logic [5:0] move_cnt;
  logic [1:0] pass_cnt;
  logic       ai_color_q;
  logic [2:0] row_q, col_q;

  logic start_game, ai_ack, hum_xfer, upd_ack, ai_turn, legal;

  // Done strobes are only honoured after the start cycle of their own wait state,
  // so a stale done from an abandoned operation cannot complete a fresh one.
  assign start_game = i_new_game && (state == S_IDLE || state == S_OVER);
  assign ai_ack     = (state == S_PROBE) && !entry && i_ai_done;
  assign hum_xfer   = (state == S_WAIT_HUM) && i_hum_valid;
  assign upd_ack    = (state == S_UPD_RUN) && !entry && i_upd_done;
  assign ai_turn    = (turn == ai_color_q);
  assign legal      = (i_upd_flip != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      entry <= 1'b0;
    end else begin
      state <= state_nxt;
      entry <= (state_nxt != state);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_OVER: if (start_game) state_nxt = S_PROBE;
      S_PROBE: begin
        if (ai_ack) begin
          if (i_ai_end)     state_nxt = S_NEXT;
          else if (ai_turn) state_nxt = S_UPD_RUN;
          else              state_nxt = S_WAIT_HUM;
        end
      end
      S_WAIT_HUM: if (hum_xfer) state_nxt = S_UPD_RUN;
      S_UPD_RUN: begin
        if (upd_ack) begin
          if (legal)        state_nxt = S_NEXT;
          else if (ai_turn) state_nxt = S_OVER;
          else              state_nxt = S_WAIT_HUM;
        end
      end
      S_NEXT: begin
        if (pass_cnt == 2'd2 || move_cnt == MAX_MOVES) state_nxt = S_OVER;
        else                                           state_nxt = S_PROBE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_hum_ready = (state == S_WAIT_HUM);
    o_ai_start  = (state == S_PROBE) && entry;
    o_ai_color  = (state == S_PROBE) && turn;
    o_upd_start = (state == S_UPD_RUN) && entry;
    o_upd_color = (state == S_UPD_RUN) && turn;
    o_pass      = ai_ack && i_ai_end;
    o_illegal   = upd_ack && !legal;
    o_game_over = (state == S_OVER);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      turn       <= BLACK;
      move_cnt   <= 6'd0;
      pass_cnt   <= 2'd0;
      ai_color_q <= WHITE;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
    end else begin
      if (start_game) begin
        turn       <= BLACK;
        move_cnt   <= 6'd0;
        pass_cnt   <= 2'd0;
        ai_color_q <= i_ai_color;
      end
      if (ai_ack) begin
        if (i_ai_end) begin
          turn     <= ~turn;
          pass_cnt <= (pass_cnt == 2'd2) ? pass_cnt : pass_cnt + 2'd1;
        end else begin
          pass_cnt <= 2'd0;
          if (ai_turn) begin
            row_q <= i_ai_row;
            col_q <= i_ai_col;
          end
        end
      end
      if (hum_xfer) begin
        row_q <= i_hum_row;
        col_q <= i_hum_col;
      end
      if (upd_ack && legal) begin
        move_cnt <= (move_cnt == MAX_MOVES) ? move_cnt : move_cnt + 6'd1;
        turn     <= ~turn;
      end
    end
  end

  assign o_turn     = turn;
  assign o_move_cnt = move_cnt;
  assign o_upd_row  = row_q;
  assign o_upd_col  = col_q;

endmodule
